// File: rtl/sim_run_ctrl_if.sv
// ============================================================================
// Module   : sim_run_ctrl_if
// Brief    : Control/status bundle between a run controller and its user.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sim_run_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic              soft_rst_req;
    logic              halt_in;
    logic [NUM_CH-1:0] rst_out;
    logic              running;
    logic              halted;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output soft_rst_req,
        output halt_in,
        input  rst_out,
        input  running,
        input  halted,
        input  timeout,
        input  cycle_cnt
    );

    modport slave (
        input  soft_rst_req,
        input  halt_in,
        output rst_out,
        output running,
        output halted,
        output timeout,
        output cycle_cnt
    );
endinterface

`default_nettype wire

// File: rtl/sim_run_ctrl.sv
// ============================================================================
// Module   : sim_run_ctrl
// Brief    : Staggered multi-channel reset sequencer with run-cycle watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sim_run_ctrl #(
    parameter int RST_CYCLES     = 25,
    parameter int NUM_CH         = 2,
    parameter int STAGGER        = 4,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    sim_run_ctrl_if.slave  bus
);

    localparam int SEQ_END = RST_CYCLES + (NUM_CH - 1) * STAGGER;
    localparam int SEQ_W   = $clog2(SEQ_END + 1) + 1;

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [SEQ_W-1:0] C_FIRST_EDGE = SEQ_W'(RST_CYCLES);
    localparam logic [SEQ_W-1:0] C_LAST_EDGE  = SEQ_W'(SEQ_END);
    localparam bit               C_TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] C_TO_LAST    = C_TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]        state_q,     state_d;
    logic [SEQ_W-1:0]  seq_q,       seq_d;
    logic [NUM_CH-1:0] rst_out_q,   rst_out_d;
    logic              running_q,   running_d;
    logic              halted_q,    halted_d;
    logic              timeout_q,   timeout_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

    logic [SEQ_W-1:0]  w_edge_num;
    logic [NUM_CH-1:0] w_ch_clear;
    logic              w_timeout;
    logic              w_last_edge;

    // seq_q holds the number of edges already seen, so this is the edge being taken now
    assign w_edge_num  = seq_q + SEQ_W'(1);
    assign w_last_edge = (w_edge_num == C_LAST_EDGE);
    assign w_timeout   = C_TO_EN && (cycle_cnt_q == C_TO_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int REL_EDGE = RST_CYCLES + i * STAGGER;
        assign w_ch_clear[i] = (w_edge_num >= SEQ_W'(REL_EDGE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HOLD;
            seq_q       <= '0;
            rst_out_q   <= '1;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            rst_out_q   <= rst_out_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.soft_rst_req) begin
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (w_last_edge) begin
                        state_d = S_RUN;
                    end else if (w_edge_num == C_FIRST_EDGE) begin
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_last_edge) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.halt_in || w_timeout) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_HOLD;
            endcase
        end
    end

    always_comb begin
        seq_d       = seq_q;
        rst_out_d   = rst_out_q;
        running_d   = running_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        cycle_cnt_d = cycle_cnt_q;
        if (bus.soft_rst_req) begin
            seq_d       = '0;
            rst_out_d   = '1;
            running_d   = 1'b0;
            halted_d    = 1'b0;
            timeout_d   = 1'b0;
            cycle_cnt_d = '0;
        end else begin
            case (state_q)
                S_HOLD, S_RELEASE: begin
                    seq_d     = w_edge_num;
                    rst_out_d = rst_out_q & ~w_ch_clear;
                    if (w_last_edge) begin
                        running_d   = 1'b1;
                        cycle_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    // halt is checked first so it wins over a coincident timeout
                    if (bus.halt_in) begin
                        running_d = 1'b0;
                        halted_d  = 1'b1;
                    end else if (w_timeout) begin
                        running_d = 1'b0;
                        timeout_d = 1'b1;
                    end else if (cycle_cnt_q != '1) begin
                        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    rst_out_d = '0;
                    running_d = 1'b0;
                end
                default: begin
                    rst_out_d = '1;
                end
            endcase
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.running   = running_q;
    assign bus.halted    = halted_q;
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
// ============================================================================
// Module   : tb_sim_run_ctrl
// Brief    : Self-checking bench for sim_run_ctrl over three parameter sets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sim_run_ctrl;

    localparam int ND = 3;
    localparam int P_RST [ND] = '{25, 25, 3};
    localparam int P_NCH [ND] = '{2, 4, 3};
    localparam int P_STG [ND] = '{4, 0, 2};
    localparam int P_TO  [ND] = '{100, 100, 0};
    localparam int P_CW  [ND] = '{32, 32, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, soft0, halt0;
    logic rst_n1, soft1, halt1;
    logic rst_n2, soft2, halt2;
    bit   done0 = 1'b0, done1 = 1'b0, done2 = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;

    sim_run_ctrl_if #(.NUM_CH(2), .CNT_W(32)) if0 ();
    sim_run_ctrl_if #(.NUM_CH(4), .CNT_W(32)) if1 ();
    sim_run_ctrl_if #(.NUM_CH(3), .CNT_W(4))  if2 ();

    assign if0.soft_rst_req = soft0;
    assign if0.halt_in      = halt0;
    assign if1.soft_rst_req = soft1;
    assign if1.halt_in      = halt1;
    assign if2.soft_rst_req = soft2;
    assign if2.halt_in      = halt2;

    sim_run_ctrl #(.RST_CYCLES(25), .NUM_CH(2), .STAGGER(4), .TIMEOUT_CYCLES(100), .CNT_W(32))
        u_dut0 (.clk(clk), .rst_n(rst_n0), .bus(if0));
    sim_run_ctrl #(.RST_CYCLES(25), .NUM_CH(4), .STAGGER(0), .TIMEOUT_CYCLES(100), .CNT_W(32))
        u_dut1 (.clk(clk), .rst_n(rst_n1), .bus(if1));
    sim_run_ctrl #(.RST_CYCLES(3), .NUM_CH(3), .STAGGER(2), .TIMEOUT_CYCLES(0), .CNT_W(4))
        u_dut2 (.clk(clk), .rst_n(rst_n2), .bus(if2));

    logic       rst_n_v [ND];
    logic       soft_v  [ND];
    logic       halt_v  [ND];
    logic [7:0] ro_v    [ND];
    logic       run_v   [ND];
    logic       hal_v   [ND];
    logic       tmo_v   [ND];
    logic [31:0] cnt_v  [ND];

    assign rst_n_v[0] = rst_n0;  assign soft_v[0] = soft0;  assign halt_v[0] = halt0;
    assign rst_n_v[1] = rst_n1;  assign soft_v[1] = soft1;  assign halt_v[1] = halt1;
    assign rst_n_v[2] = rst_n2;  assign soft_v[2] = soft2;  assign halt_v[2] = halt2;

    assign ro_v[0]  = 8'(if0.rst_out);    assign ro_v[1]  = 8'(if1.rst_out);    assign ro_v[2]  = 8'(if2.rst_out);
    assign run_v[0] = if0.running;        assign run_v[1] = if1.running;        assign run_v[2] = if2.running;
    assign hal_v[0] = if0.halted;         assign hal_v[1] = if1.halted;         assign hal_v[2] = if2.halted;
    assign tmo_v[0] = if0.timeout;        assign tmo_v[1] = if1.timeout;        assign tmo_v[2] = if2.timeout;
    assign cnt_v[0] = 32'(if0.cycle_cnt); assign cnt_v[1] = 32'(if1.cycle_cnt); assign cnt_v[2] = 32'(if2.cycle_cnt);

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: m_e = edges counted in the current sequence, capped at the last release edge
    int     m_e   [ND];
    bit     m_h   [ND];
    bit     m_t   [ND];
    bit     m_end [ND];
    longint m_c   [ND];

    function automatic int seq_end(input int d);
        return P_RST[d] + (P_NCH[d] - 1) * P_STG[d];
    endfunction

    function automatic void m_reset(input int d);
        m_e[d] = 0; m_h[d] = 1'b0; m_t[d] = 1'b0; m_end[d] = 1'b0; m_c[d] = 0;
    endfunction

    function automatic longint exp_ro(input int d);
        longint r = 0;
        for (int i = 0; i < P_NCH[d]; i++)
            if (m_e[d] < P_RST[d] + i * P_STG[d]) r = r | (longint'(1) << i);
        return r;
    endfunction

    initial for (int d = 0; d < ND; d++) m_reset(d);

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n_v[d] || soft_v[d]) begin
                m_reset(d);
            end else if (!m_end[d] && m_e[d] >= seq_end(d)) begin
                if (halt_v[d]) begin
                    m_h[d] = 1'b1; m_end[d] = 1'b1;
                end else if (P_TO[d] != 0 && m_c[d] == P_TO[d] - 1) begin
                    m_t[d] = 1'b1; m_end[d] = 1'b1;
                end else if (m_c[d] < (longint'(1) << P_CW[d]) - 1) begin
                    m_c[d] = m_c[d] + 1;
                end
            end else if (!m_end[d]) begin
                m_e[d] = m_e[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n_v[d]) m_reset(d);
            check($sformatf("d%0d_rst_out", d),   ro_v[d],  exp_ro(d));
            check($sformatf("d%0d_running", d),   run_v[d], longint'(m_e[d] >= seq_end(d) && !m_end[d]));
            check($sformatf("d%0d_halted", d),    hal_v[d], longint'(m_h[d]));
            check($sformatf("d%0d_timeout", d),   tmo_v[d], longint'(m_t[d]));
            check($sformatf("d%0d_cycle_cnt", d), cnt_v[d], m_c[d]);
        end
    end

    initial begin : stim0
        rst_n0 = 1'b1; soft0 = 1'b0; halt0 = 1'b0;
        #2 rst_n0 = 1'b0;
        tick(3);
        check("d0_reset_ro", if0.rst_out, 3);
        check("d0_reset_cnt", if0.cycle_cnt, 0);
        rst_n0 = 1'b1;
        tick(24); check("d0_e24_ro", if0.rst_out, 3);
        tick(1);  check("d0_e25_ro", if0.rst_out, 2);  check("d0_e25_run", if0.running, 0);
        tick(4);  check("d0_e29_ro", if0.rst_out, 0);  check("d0_e29_run", if0.running, 1);
                  check("d0_e29_cnt", if0.cycle_cnt, 0);
        tick(99); check("d0_e128_run", if0.running, 1); check("d0_e128_cnt", if0.cycle_cnt, 99);
        tick(1);  check("d0_e129_tmo", if0.timeout, 1); check("d0_e129_run", if0.running, 0);
                  check("d0_e129_cnt", if0.cycle_cnt, 99); check("d0_e129_hal", if0.halted, 0);
        tick(5);  check("d0_done_cnt", if0.cycle_cnt, 99); check("d0_done_ro", if0.rst_out, 0);
        // restart from DONE with timeout set
        soft0 = 1'b1; tick(1);
        check("d0_soft_ro", if0.rst_out, 3); check("d0_soft_tmo", if0.timeout, 0);
        check("d0_soft_cnt", if0.cycle_cnt, 0);
        soft0 = 1'b0;
        tick(25); check("d0_soft_e25_ro", if0.rst_out, 2);
        tick(4);  check("d0_soft_e29_ro", if0.rst_out, 0); check("d0_soft_e29_run", if0.running, 1);
        // halt sampled at cycle_cnt 40
        tick(40); check("d0_pre_halt_cnt", if0.cycle_cnt, 40);
        halt0 = 1'b1; tick(1);
        check("d0_halt_hal", if0.halted, 1); check("d0_halt_run", if0.running, 0);
        check("d0_halt_cnt", if0.cycle_cnt, 40);
        halt0 = 1'b0;
        tick(80); check("d0_halt_no_tmo", if0.timeout, 0); check("d0_halt_frz", if0.cycle_cnt, 40);
        halt0 = 1'b1; tick(2); halt0 = 1'b0; tick(1);
        check("d0_halt_again", if0.halted, 1); check("d0_halt_again_cnt", if0.cycle_cnt, 40);
        // halt coincident with the timeout edge
        soft0 = 1'b1; tick(1); soft0 = 1'b0;
        tick(29); tick(99); check("d0_tie_pre_cnt", if0.cycle_cnt, 99);
        halt0 = 1'b1; tick(1); halt0 = 1'b0;
        check("d0_tie_hal", if0.halted, 1); check("d0_tie_tmo", if0.timeout, 0);
        check("d0_tie_cnt", if0.cycle_cnt, 99);
        tick(3); check("d0_tie_tmo2", if0.timeout, 0);
        // restart during RUN
        soft0 = 1'b1; tick(1); soft0 = 1'b0;
        tick(29); tick(10); check("d0_run10_cnt", if0.cycle_cnt, 10);
        soft0 = 1'b1; tick(1);
        check("d0_runsoft_ro", if0.rst_out, 3); check("d0_runsoft_run", if0.running, 0);
        check("d0_runsoft_cnt", if0.cycle_cnt, 0);
        soft0 = 1'b0;
        tick(25); check("d0_runsoft_e25", if0.rst_out, 2);
        tick(4);  check("d0_runsoft_e29", if0.rst_out, 0);
        // asynchronous reset mid-RELEASE
        soft0 = 1'b1; tick(1); soft0 = 1'b0;
        tick(26); check("d0_rel_ro", if0.rst_out, 2);
        #1 rst_n0 = 1'b0;
        #1 check("d0_async_ro", if0.rst_out, 3);
        tick(2); rst_n0 = 1'b1;
        tick(25); check("d0_after_async_e25", if0.rst_out, 2);
        done0 = 1'b1;
    end

    initial begin : stim1
        rst_n1 = 1'b1; soft1 = 1'b0; halt1 = 1'b0;
        #2 rst_n1 = 1'b0;
        tick(3); check("d1_reset_ro", if1.rst_out, 15);
        rst_n1 = 1'b1;
        tick(24); check("d1_e24_ro", if1.rst_out, 15); check("d1_e24_run", if1.running, 0);
        tick(1);  check("d1_e25_ro", if1.rst_out, 0);  check("d1_e25_run", if1.running, 1);
                  check("d1_e25_cnt", if1.cycle_cnt, 0);
        // halt during HOLD is ignored
        soft1 = 1'b1; tick(1); soft1 = 1'b0; halt1 = 1'b1;
        tick(10); check("d1_hold_halt", if1.halted, 0); check("d1_hold_ro", if1.rst_out, 15);
        halt1 = 1'b0;
        tick(15); check("d1_e25b_run", if1.running, 1); check("d1_e25b_hal", if1.halted, 0);
        tick(5);  check("d1_cnt5", if1.cycle_cnt, 5);
        halt1 = 1'b1; tick(1); halt1 = 1'b0;
        check("d1_halt_hal", if1.halted, 1); check("d1_halt_cnt", if1.cycle_cnt, 5);
        check("d1_halt_tmo", if1.timeout, 0);
        done1 = 1'b1;
    end

    initial begin : stim2
        rst_n2 = 1'b1; soft2 = 1'b0; halt2 = 1'b0;
        #2 rst_n2 = 1'b0;
        tick(2); rst_n2 = 1'b1;
        tick(2); check("d2_e2_ro", if2.rst_out, 7);
        tick(1); check("d2_e3_ro", if2.rst_out, 6);
        tick(2); check("d2_e5_ro", if2.rst_out, 4);
        tick(1); check("d2_e6_ro", if2.rst_out, 4); check("d2_e6_run", if2.running, 0);
        tick(1); check("d2_e7_ro", if2.rst_out, 0); check("d2_e7_run", if2.running, 1);
        tick(15); check("d2_cnt15", if2.cycle_cnt, 15);
        tick(10); check("d2_sat_cnt", if2.cycle_cnt, 15); check("d2_sat_run", if2.running, 1);
                  check("d2_sat_tmo", if2.timeout, 0);
        // soft_rst_req held high keeps the sequence parked
        soft2 = 1'b1; tick(20);
        check("d2_hold_ro", if2.rst_out, 7); check("d2_hold_cnt", if2.cycle_cnt, 0);
        soft2 = 1'b0;
        tick(3); check("d2_re3_ro", if2.rst_out, 6);
        tick(4); check("d2_re7_run", if2.running, 1);
        tick(3); check("d2_cnt3", if2.cycle_cnt, 3);
        halt2 = 1'b1; tick(1); halt2 = 1'b0;
        check("d2_halt_hal", if2.halted, 1); check("d2_halt_cnt", if2.cycle_cnt, 3);
        check("d2_halt_run", if2.running, 0);
        done2 = 1'b1;
    end

    initial begin : main
        int waited;
        waited = 0;
        while (waited < 5000 && !(done0 && done1 && done2)) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (!(done0 && done1 && done2)) begin
            n_errs++;
            $display("FAIL watchdog: stimulus done flags %0d%0d%0d, required 111", done0, done1, done2);
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Parametrised reset sequencer and run watchdog for simulation and bring-up of riscv_top and multi-core variants.
- Holds N downstream reset channels asserted for a programmable number of cycles, then releases them in staggered order.
- Counts run cycles and ends the run on a core halt or a cycle timeout.
- Replaces fixed bench-side delay loops with a reusable, synthesizable controller driving btnC-style active-high resets.

Parameters:
- RST_CYCLES, 25, cycles rst_out[0] stays asserted after rst_n deasserts (>=1)
- NUM_CH, 2, number of reset channels (>=1)
- STAGGER, 4, cycles between successive channel releases (>=0)
- TIMEOUT_CYCLES, 100, run length limit in cycles; 0 disables timeout
- CNT_W, 32, width of cycle counter; TIMEOUT_CYCLES must be < 2^CNT_W

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- soft_rst_req  input  1  synchronous restart request, level, active-high
- halt_in  input  1  core halt/done indication, active-high
- rst_out  output  NUM_CH  per-channel active-high reset to downstream blocks
- running  output  1  high while all channels are released and run is live
- halted  output  1  sticky: run ended by halt_in
- timeout  output  1  sticky: run ended by timeout
- cycle_cnt  output  CNT_W  run cycle count, frozen at run end

Behaviour:
- Async reset (rst_n low):
  - rst_out = all ones; running=0, halted=0, timeout=0, cycle_cnt=0.
  - State = HOLD; internal counters = 0.
  - Takes effect immediately in any state, including mid-RELEASE and mid-RUN.
- States: HOLD -> RELEASE -> RUN -> DONE. DONE is sticky.
- All outputs are registered; no combinational path from any input to any output.
- Edge numbering: edge k = k-th rising clk edge with rst_n high after deassert.
- HOLD:
  - hold counter increments each edge.
  - At edge RST_CYCLES: rst_out[0] <= 0. If NUM_CH==1 or STAGGER==0, all channels clear, running <= 1 and state goes to RUN; otherwise state goes to RELEASE.
- RELEASE:
  - rst_out[i] clears at edge RST_CYCLES + i*STAGGER.
  - At the edge the last channel clears, running <= 1, cycle_cnt <= 0, state goes to RUN.
  - Released channels never re-assert except via rst_n or soft_rst_req.
- RUN:
  - cycle_cnt increments by 1 each edge.
  - halt_in high at an edge: running <= 0, halted <= 1, cycle_cnt holds (not incremented), state goes to DONE.
  - Timeout, when TIMEOUT_CYCLES != 0: at the edge where cycle_cnt == TIMEOUT_CYCLES-1 and halt_in is low, timeout <= 1, running <= 0, cycle_cnt holds, state goes to DONE. running is therefore high for exactly TIMEOUT_CYCLES cycles.
  - halt_in and timeout at the same edge: halt wins (halted=1, timeout=0).
  - TIMEOUT_CYCLES==0: cycle_cnt saturates at all ones and never wraps; only halt_in ends the run.
- halt_in is ignored outside RUN.
- DONE:
  - rst_out stays all zeros.
  - running=0; halted/timeout/cycle_cnt are held.
- soft_rst_req high at any edge, any state, with priority over halt_in and timeout:
  - rst_out <= all ones; running, halted, timeout, cycle_cnt <= 0.
  - State = HOLD with hold counter = 0.
  - The next sequence counts from the first edge with soft_rst_req low (that edge = edge 1).
- soft_rst_req held high keeps the block in HOLD with counter 0.
- Exactly one of halted/timeout can be set at a time.

Test Plan:
- Defaults; rst_n low 3 cycles then high -> rst_out=2'b11 through edge 24; rst_out=2'b10 at edge 25; rst_out=2'b00 and running=1 at edge 29; cycle_cnt=0 at edge 29.
- Defaults, halt_in held 0 -> running high edges 29..128; timeout=1 and running=0 at edge 129; cycle_cnt=99 and stays 99; halted=0.
- halt_in pulsed 1 cycle sampled when cycle_cnt=40 -> halted=1, running=0 next edge; cycle_cnt frozen at 40; timeout never sets; later halt_in pulses have no effect.
- halt_in high at the edge where cycle_cnt=99 -> halted=1, timeout=0, cycle_cnt=99.
- soft_rst_req 1-cycle pulse during RUN at cycle_cnt=10 -> rst_out=2'b11, running=0, cycle_cnt=0 next edge; rst_out[0] falls 25 and rst_out[1] falls 29 edges after the pulse's trailing edge. Repeat in DONE with timeout=1 -> timeout clears.
- rst_n pulled low mid-RELEASE (rst_out=2'b10), asynchronously between edges -> rst_out=2'b11 immediately, before the next clk edge. Then NUM_CH=4, STAGGER=0 -> all four release together at edge 25. Then halt_in high during HOLD -> ignored, halted=0.
